// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// State codes are fixed because they are exported on the State debug port.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BNE      = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // States that touch the shared memory and therefore stretch by MEM_LAT.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp request plus the instruction Funct field to ALUControl.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with MEM_LAT memory wait states.
// Define MIPS_BNE_EN to add the bne instruction (opcode 000101, state BNE).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  state_t     state, next_state, dec_next;
  logic [1:0] cnt, next_cnt;
  logic       last;
  aluop_t     aluop;
  logic       alu_used;
  logic       pcwrite, branch, branch_ne;
  logic [2:0] alu_ctl;

  assign last = (cnt == LAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    dec_next = S_FETCH;
    case (Opcode)
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_RTYPE:     dec_next = S_EXECUTE;
      OP_BEQ:       dec_next = S_BRANCH;
      OP_ADDI:      dec_next = S_ADDIEX;
      OP_J:         dec_next = S_JUMP;
`ifdef MIPS_BNE_EN
      OP_BNE:       dec_next = S_BNE;
`endif
      default:      dec_next = S_FETCH;
    endcase
  end

  // Memory states hold while the counter runs; every exit clears the counter.
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    if (is_mem_state(state) && !last) begin
      next_cnt = cnt + 2'd1;
    end else begin
      case (state)
        S_FETCH:   next_state = S_DECODE;
        S_DECODE:  next_state = dec_next;
        S_MEMADR:  next_state = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: next_state = S_MEMWB;
        S_EXECUTE: next_state = S_ALUWB;
        S_ADDIEX:  next_state = S_ADDIWB;
        default:   next_state = S_FETCH;
      endcase
    end
  end

  always_comb begin
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    Illegal   = 1'b0;
    State     = '0;
    aluop     = ALUOP_ADD;
    alu_used  = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    if (!rst) begin
      State = state;
      case (state)
        S_FETCH: begin
          ALUSrcB  = 2'b01;
          alu_used = 1'b1;
          IRWrite  = last;
          pcwrite  = last;
        end
        S_DECODE: begin
          ALUSrcB  = 2'b11;
          alu_used = 1'b1;
          Illegal  = (dec_next == S_FETCH);
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          alu_used = 1'b1;
        end
        S_MEMREAD: IorD = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = last;
        end
        S_EXECUTE: begin
          ALUSrcA  = 1'b1;
          aluop    = ALUOP_FUNCT;
          alu_used = 1'b1;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          aluop    = ALUOP_SUB;
          alu_used = 1'b1;
          PCSrc    = 2'b01;
          branch   = 1'b1;
        end
`ifdef MIPS_BNE_EN
        S_BNE: begin
          ALUSrcA   = 1'b1;
          aluop     = ALUOP_SUB;
          alu_used  = 1'b1;
          PCSrc     = 2'b01;
          branch_ne = 1'b1;
        end
`endif
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (Funct),
    .alucontrol (alu_ctl)
  );

  // States that leave the ALU idle present 000 rather than the decoder's add.
  assign ALUControl = alu_used ? alu_ctl : '0;
  assign PCEn       = pcwrite | (branch & Zero) | (branch_ne & ~Zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl at MEM_LAT=0 and MEM_LAT=2.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [2:0] aluctl;
    logic       illegal;
    logic [3:0] st;
  } outs_t;

`ifdef MIPS_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       sel = 1'b0;

  logic       iord0, mw0, irw0, pcen0, asa0, rd0, m2r0, rw0, ill0;
  logic [1:0] asb0, pcs0;
  logic [2:0] ac0;
  logic [3:0] st0;
  logic       iord2, mw2, irw2, pcen2, asa2, rd2, m2r2, rw2, ill2;
  logic [1:0] asb2, pcs2;
  logic [2:0] ac2;
  logic [3:0] st2;
  outs_t      obs0, obs2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  outs_t       expq[$];
  string       tagq[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .Opcode(opcode), .Funct(funct), .Zero(zero),
    .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .PCEn(pcen0),
    .ALUSrcA(asa0), .ALUSrcB(asb0), .PCSrc(pcs0), .RegDst(rd0),
    .MemtoReg(m2r0), .RegWrite(rw0), .ALUControl(ac0), .Illegal(ill0),
    .State(st0)
  );

  mips_multicycle_ctrl #(.MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .Opcode(opcode), .Funct(funct), .Zero(zero),
    .IorD(iord2), .MemWrite(mw2), .IRWrite(irw2), .PCEn(pcen2),
    .ALUSrcA(asa2), .ALUSrcB(asb2), .PCSrc(pcs2), .RegDst(rd2),
    .MemtoReg(m2r2), .RegWrite(rw2), .ALUControl(ac2), .Illegal(ill2),
    .State(st2)
  );

  assign obs0 = {iord0, mw0, irw0, pcen0, asa0, asb0, pcs0, rd0, m2r0, rw0, ac0, ill0, st0};
  assign obs2 = {iord2, mw2, irw2, pcen2, asa2, asb2, pcs2, rd2, m2r2, rw2, ac2, ill2, st2};

  // Expected outputs per state as listed in the control table; f is the
  // per-state qualifier (final wait cycle, Illegal, or taken branch).
  function automatic outs_t ex(input int unsigned s, input logic f, input logic [2:0] ctl);
    outs_t e;
    e    = '0;
    e.st = 4'(s);
    case (s)
      0:     begin e.alusrcb = 2'b01; e.aluctl = 3'b010; e.irwrite = f; e.pcen = f; end
      1:     begin e.alusrcb = 2'b11; e.aluctl = 3'b010; e.illegal = f; end
      2, 9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = 3'b010; end
      3:     e.iord = 1'b1;
      4:     begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:     begin e.iord = 1'b1; e.memwrite = f; end
      6:     begin e.alusrca = 1'b1; e.aluctl = ctl; end
      7:     begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8, 12: begin e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = f; end
      10:    e.regwrite = 1'b1;
      11:    begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input outs_t e, input string nm);
    expq.push_back(e);
    tagq.push_back(nm);
  endtask

  task automatic rst_cycles(input int unsigned n, input logic s);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      rst = 1'b1;
      sel = s;
      push('0, "reset_outputs");
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic [2:0] ctl, input int unsigned lat, input string nm);
    logic ill;
    tick();
    rst    = 1'b0;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int unsigned i = 0; i <= lat; i++) begin
      if (i > 0) tick();
      push(ex(0, i == lat, 3'b000), {nm, "_fetch"});
    end
    ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
            op == 6'b001000 || op == 6'b000010 || (op == 6'b000101 && BNE_EN));
    tick();
    push(ex(1, ill, 3'b000), {nm, "_decode"});
    case (op)
      6'b100011: begin
        tick(); push(ex(2, 1'b0, 3'b000), {nm, "_memadr"});
        for (int unsigned i = 0; i <= lat; i++) begin
          tick(); push(ex(3, 1'b0, 3'b000), {nm, "_memread"});
        end
        tick(); push(ex(4, 1'b0, 3'b000), {nm, "_memwb"});
      end
      6'b101011: begin
        tick(); push(ex(2, 1'b0, 3'b000), {nm, "_memadr"});
        for (int unsigned i = 0; i <= lat; i++) begin
          tick(); push(ex(5, i == lat, 3'b000), {nm, "_memwrite"});
        end
      end
      6'b000000: begin
        tick(); push(ex(6, 1'b0, ctl), {nm, "_execute"});
        tick(); push(ex(7, 1'b0, 3'b000), {nm, "_aluwb"});
      end
      6'b000100: begin
        tick(); push(ex(8, z, 3'b000), {nm, "_branch"});
      end
      6'b000101: begin
        if (BNE_EN) begin
          tick(); push(ex(12, !z, 3'b000), {nm, "_bne"});
        end
      end
      6'b001000: begin
        tick(); push(ex(9, 1'b0, 3'b000), {nm, "_addiex"});
        tick(); push(ex(10, 1'b0, 3'b000), {nm, "_addiwb"});
      end
      6'b000010: begin
        tick(); push(ex(11, 1'b1, 3'b000), {nm, "_jump"});
      end
      default: ;
    endcase
  endtask

  task automatic tail_fetch(input int unsigned lat);
    tick();
    push(ex(0, lat == 0, 3'b000), "tail_fetch");
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin : monitor
    outs_t e, o;
    string nm;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        nm = tagq.pop_front();
        o  = sel ? obs2 : obs0;
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got %b (state %0d) want %b (state %0d)", nm, o, o.st, e, e.st);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_cycles(2, 1'b0);
    run_instr(6'b100011, 6'b000000, 1'b0, 3'b000, 0, "lw");
    run_instr(6'b000000, 6'b101010, 1'b0, 3'b111, 0, "slt");
    run_instr(6'b000000, 6'b100000, 1'b0, 3'b010, 0, "add");
    run_instr(6'b000000, 6'b100010, 1'b0, 3'b110, 0, "sub");
    run_instr(6'b000000, 6'b100100, 1'b0, 3'b000, 0, "and");
    run_instr(6'b000000, 6'b100101, 1'b0, 3'b001, 0, "or");
    run_instr(6'b000000, 6'b000111, 1'b0, 3'b010, 0, "funct_default");
    run_instr(6'b101011, 6'b000000, 1'b0, 3'b000, 0, "sw");
    run_instr(6'b001000, 6'b000000, 1'b0, 3'b000, 0, "addi");
    run_instr(6'b000100, 6'b000000, 1'b1, 3'b000, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 3'b000, 0, "beq_not_taken");
    run_instr(6'b000010, 6'b000000, 1'b0, 3'b000, 0, "j");
    run_instr(6'b111111, 6'b000000, 1'b0, 3'b000, 0, "illegal");
    run_instr(6'b000101, 6'b000000, 1'b0, 3'b000, 0, "bne_zero0");
    run_instr(6'b000101, 6'b000000, 1'b1, 3'b000, 0, "bne_zero1");
    tail_fetch(0);

    rst_cycles(2, 1'b1);
    run_instr(6'b101011, 6'b000000, 1'b0, 3'b000, 2, "sw_lat2");
    run_instr(6'b100011, 6'b000000, 1'b0, 3'b000, 2, "lw_lat2");
    run_instr(6'b000100, 6'b000000, 1'b1, 3'b000, 2, "beq_lat2");

    // lw interrupted by reset in the middle of MEMREAD.
    tick(); rst = 1'b0; opcode = 6'b100011; push(ex(0, 1'b0, 3'b000), "mid_fetch");
    tick(); push(ex(0, 1'b0, 3'b000), "mid_fetch");
    tick(); push(ex(0, 1'b1, 3'b000), "mid_fetch");
    tick(); push(ex(1, 1'b0, 3'b000), "mid_decode");
    tick(); push(ex(2, 1'b0, 3'b000), "mid_memadr");
    tick(); push(ex(3, 1'b0, 3'b000), "mid_memread");
    tick(); push(ex(3, 1'b0, 3'b000), "mid_memread");
    rst_cycles(1, 1'b1);
    run_instr(6'b100011, 6'b000000, 1'b0, 3'b000, 2, "lw_after_rst");
    tail_fetch(2);

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", expq.size());
    end
    summary();
    $finish;
  end

endmodule
